pc_gen: RTL and testbench

- Parametrised program-counter generator for the pipelined MIPS core. Sits at the front of the IF stage and drives the instruction-memory address.
- Adds the following over the basic PC register:
  - prioritised next-PC selection: sequential, branch, jump, jr, exception, eret
  - stall
  - a one-bit exception-level (EXL) state with EPC capture
  - combinational fetch-fault detection (misaligned or out-of-range PC)
  - a saturating redirect counter

---
 rtl/pc_gen.sv | 104 ++++++++++
 tb/tb_pc_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - IF-stage program-counter generator with prioritised redirects,
// stall, EXL/EPC state, fetch-fault flag and saturating redirect counter.
module pc_gen #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = 32'h0000_3000,
  parameter logic [WIDTH-1:0]   EXC_VEC  = 32'h0000_4180,
  parameter logic [WIDTH-1:0]   ADDR_LO  = 32'h0000_3000,
  parameter logic [WIDTH-1:0]   ADDR_HI  = 32'h0000_6ffc,
  parameter int                 CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc_now,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             exl,
  output logic             fetch_fault,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {
    NORMAL = 1'b0,
    EXC    = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] epc_reg, epc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             redirect;

  assign pc_now       = pc_reg;
  assign pc_plus4     = pc_reg + WIDTH'(4);
  assign epc          = epc_reg;
  assign exl          = (state == EXC);
  assign redirect_cnt = cnt_reg;

  // Flag only; the pipeline converts a fault into exc_req.
  assign fetch_fault = (pc_reg[1:0] != 2'b00) | (pc_reg < ADDR_LO) | (pc_reg > ADDR_HI);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= NORMAL;
      pc_reg  <= RESET_PC;
      epc_reg <= '0;
      cnt_reg <= '0;
    end else begin
      state   <= state_next;
      pc_reg  <= pc_next;
      epc_reg <= epc_next;
      cnt_reg <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_reg;
    epc_next   = epc_reg;
    redirect   = 1'b0;

    // exc_req and eret bypass the stall; exc_req also masks a coincident eret.
    if (exc_req) begin
      pc_next    = EXC_VEC;
      redirect   = 1'b1;
      state_next = EXC;
      if (state == NORMAL) begin
        epc_next = exc_pc;
      end
    end else if (eret) begin
      pc_next    = epc_reg;
      redirect   = 1'b1;
      state_next = NORMAL;
    end else if (en) begin
      if (jr) begin
        pc_next  = jr_target;
        redirect = 1'b1;
      end else if (jmp) begin
        pc_next  = jmp_target;
        redirect = 1'b1;
      end else if (br_taken) begin
        pc_next  = br_target;
        redirect = 1'b1;
      end else begin
        pc_next  = pc_plus4;
      end
    end

    cnt_next = cnt_reg;
    if (redirect && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed table-driven bench for pc_gen, plus a narrow-counter
// instance for saturation and a hand-written asynchronous-clear sequence.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        clr;
  logic        en, br_taken, jmp, jr, exc_req, eret;
  logic [31:0] br_target, jmp_target, jr_target, exc_pc;
  logic [31:0] pc_now, pc_plus4, epc;
  logic        exl, fetch_fault;
  logic [15:0] redirect_cnt;
  logic [31:0] s_pc_now, s_pc_plus4, s_epc;
  logic        s_exl, s_fetch_fault;
  logic [2:0]  s_redirect_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .clr(clr), .en(en),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target),
    .jr(jr), .jr_target(jr_target),
    .exc_req(exc_req), .exc_pc(exc_pc), .eret(eret),
    .pc_now(pc_now), .pc_plus4(pc_plus4), .epc(epc), .exl(exl),
    .fetch_fault(fetch_fault), .redirect_cnt(redirect_cnt)
  );

  pc_gen #(.CNT_W(3)) dut_small (
    .clk(clk), .clr(clr), .en(en),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target),
    .jr(jr), .jr_target(jr_target),
    .exc_req(exc_req), .exc_pc(exc_pc), .eret(eret),
    .pc_now(s_pc_now), .pc_plus4(s_pc_plus4), .epc(s_epc), .exl(s_exl),
    .fetch_fault(s_fetch_fault), .redirect_cnt(s_redirect_cnt)
  );

  typedef struct {
    logic        en, br, jmp, jr, exc, eret;
    logic [31:0] br_t, jmp_t, jr_t, exc_pc;
    logic [31:0] pc, epc;
    logic        exl, fault;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic b, input logic j, input logic r,
                     input logic x, input logic t,
                     input logic [31:0] bt, input logic [31:0] jt,
                     input logic [31:0] rt, input logic [31:0] xp,
                     input logic [31:0] pc, input logic [31:0] ep,
                     input logic xl, input logic f, input logic [15:0] c);
    vec_t v;
    v.en = e; v.br = b; v.jmp = j; v.jr = r; v.exc = x; v.eret = t;
    v.br_t = bt; v.jmp_t = jt; v.jr_t = rt; v.exc_pc = xp;
    v.pc = pc; v.epc = ep; v.exl = xl; v.fault = f; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    en = 1'b0; br_taken = 1'b0; jmp = 1'b0; jr = 1'b0; exc_req = 1'b0; eret = 1'b0;
    br_target = '0; jmp_target = '0; jr_target = '0; exc_pc = '0;
  endtask

  initial begin
    //   en br jm jr ex er  br_t          jmp_t         jr_t          exc_pc        | pc            epc           exl flt cnt
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h3004,     32'h0,    0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h3008,     32'h0,    0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h300c,     32'h0,    0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h3010,     32'h0,    0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 32'h3100,     32'h0,        32'h0,        32'h0,        32'h3010,     32'h0,    0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 32'h3100,     32'h0,        32'h0,        32'h0,        32'h3010,     32'h0,    0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 32'h3100,     32'h0,        32'h0,        32'h0,        32'h3010,     32'h0,    0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 32'h3100,     32'h0,        32'h0,        32'h0,        32'h3100,     32'h0,    0, 0, 1);
    add(1, 1, 1, 1, 0, 0, 32'h3400,     32'h3300,     32'h3200,     32'h0,        32'h3200,     32'h0,    0, 0, 2);
    add(1, 1, 1, 0, 0, 0, 32'h3400,     32'h3300,     32'h0,        32'h0,        32'h3300,     32'h0,    0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0,        32'h3050,     32'h4180,     32'h3050, 1, 0, 4);
    add(1, 0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0,        32'h4184,     32'h4180,     32'h3050, 1, 0, 5);
    add(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        32'h3050,     32'h3050, 0, 0, 6);
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h3054,     32'h3050, 0, 0, 6);
    add(1, 0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0,        32'h3054,     32'h4180,     32'h3054, 1, 0, 7);
    add(1, 0, 0, 0, 1, 1, 32'h0,        32'h0,        32'h0,        32'h3100,     32'h4180,     32'h3054, 1, 0, 8);
    add(1, 0, 0, 1, 0, 1, 32'h0,        32'h0,        32'h3200,     32'h0,        32'h3054,     32'h3054, 0, 0, 9);
    add(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        32'h3054,     32'h3054, 0, 0, 10);
    add(1, 0, 1, 0, 0, 0, 32'h0,        32'h3002,     32'h0,        32'h0,        32'h3002,     32'h3054, 0, 1, 11);
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h3006,     32'h3054, 0, 1, 11);
    add(1, 0, 1, 0, 0, 0, 32'h0,        32'h7000,     32'h0,        32'h0,        32'h7000,     32'h3054, 0, 1, 12);
    add(1, 0, 1, 0, 0, 0, 32'h0,        32'h6ffc,     32'h0,        32'h0,        32'h6ffc,     32'h3054, 0, 0, 13);
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h7000,     32'h3054, 0, 1, 13);
    add(1, 1, 0, 0, 0, 0, 32'h2ffc,     32'h0,        32'h0,        32'h0,        32'h2ffc,     32'h3054, 0, 1, 14);
    add(1, 0, 0, 1, 0, 0, 32'h0,        32'h0,        32'hffff_fffc, 32'h0,       32'hffff_fffc, 32'h3054, 0, 1, 15);
    add(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h3054, 0, 1, 15);

    idle();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset pc_now", pc_now, 32'h3000);
    check("reset pc_plus4", pc_plus4, 32'h3004);
    check("reset epc", epc, 32'h0);
    check("reset exl", {31'b0, exl}, 32'h0);
    check("reset cnt", {16'b0, redirect_cnt}, 32'h0);
    check("reset fault", {31'b0, fetch_fault}, 32'h0);
    clr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      en = vecs[i].en; br_taken = vecs[i].br; jmp = vecs[i].jmp; jr = vecs[i].jr;
      exc_req = vecs[i].exc; eret = vecs[i].eret;
      br_target = vecs[i].br_t; jmp_target = vecs[i].jmp_t;
      jr_target = vecs[i].jr_t; exc_pc = vecs[i].exc_pc;
      @(posedge clk);
      #1;
      check($sformatf("v%0d pc_now", i), pc_now, vecs[i].pc);
      check($sformatf("v%0d pc_plus4", i), pc_plus4, vecs[i].pc + 32'd4);
      check($sformatf("v%0d epc", i), epc, vecs[i].epc);
      check($sformatf("v%0d exl", i), {31'b0, exl}, {31'b0, vecs[i].exl});
      check($sformatf("v%0d fault", i), {31'b0, fetch_fault}, {31'b0, vecs[i].fault});
      check($sformatf("v%0d cnt", i), {16'b0, redirect_cnt}, {16'b0, vecs[i].cnt});
      check($sformatf("v%0d sat_cnt", i), {29'b0, s_redirect_cnt},
            (vecs[i].cnt > 16'd7) ? 32'd7 : {16'b0, vecs[i].cnt});
    end

    // Enter EXC, then pulse clr between edges and release it before the next edge.
    @(negedge clk);
    idle();
    exc_req = 1'b1; exc_pc = 32'h3000;
    @(posedge clk);
    #1;
    check("pre-clr exl", {31'b0, exl}, 32'h1);
    @(negedge clk);
    idle();
    #2;
    clr = 1'b1;
    #1;
    check("async pc_now", pc_now, 32'h3000);
    check("async exl", {31'b0, exl}, 32'h0);
    check("async cnt", {16'b0, redirect_cnt}, 32'h0);
    check("async epc", epc, 32'h0);
    check("async sat_cnt", {29'b0, s_redirect_cnt}, 32'h0);
    clr = 1'b0;
    en = 1'b1;
    #1;
    check("release hold pc", pc_now, 32'h3000);
    @(posedge clk);
    #1;
    check("first edge pc", pc_now, 32'h3004);
    check("first edge cnt", {16'b0, redirect_cnt}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
